// File: rtl/interp_phase_scheduler.sv
// rtl/interp_phase_scheduler.sv - 4x fractional-delay interpolator sharing one MAC across three phases
module interp_phase_scheduler #(
    parameter int DW = 14,
    parameter int CW = 12,
    parameter int AW = 25,
    parameter int SH = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [DW-1:0] xin,
    input  logic          ovr_clr,
    output logic          ready,
    output logic [DW-1:0] y,
    output logic          y_valid,
    output logic [1:0]    y_phase,
    output logic          ovr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OUT0 = 2'd1,
        S_MAC  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic signed [DW-1:0] r_x0, r_x1, r_x2, r_x3;
    logic signed [AW-1:0] r_acc;
    logic [1:0]           r_p;
    logic [1:0]           r_t;

    logic signed [DW-1:0] r_y;
    logic                 r_y_valid;
    logic [1:0]           r_y_phase;
    logic                 r_ovr;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_last_tap;

    logic signed [CW-1:0] w_coef;
    logic signed [DW-1:0] w_xt;
    logic signed [AW-1:0] w_prod;
    logic signed [AW-1:0] w_sum;
    logic signed [DW-1:0] w_y_new;

    // State register; reset abandons any computation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: one cycle for the pass-through tap, then 3 phases x 4 taps
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (sample_valid) w_next_state = S_OUT0;
            S_OUT0: w_next_state = S_MAC;
            S_MAC:  if (r_t == 2'd3 && r_p == 2'd3) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Decoded controls: strobes outside IDLE are dropped and flagged
    always_comb begin
        w_ready    = (r_state == S_IDLE);
        w_accept   = sample_valid && (r_state == S_IDLE);
        w_drop     = sample_valid && (r_state != S_IDLE);
        w_last_tap = (r_state == S_MAC) && (r_t == 2'd3);
    end

    // Coefficient ROM; phase 2 is symmetric, phases 1 and 3 are mirror images
    always_comb begin
        w_coef = '0;
        case ({r_p, r_t})
            4'b01_00: w_coef = CW'(-58);
            4'b01_01: w_coef = CW'(843);
            4'b01_10: w_coef = CW'(281);
            4'b01_11: w_coef = CW'(-42);
            4'b10_00: w_coef = CW'(-67);
            4'b10_01: w_coef = CW'(579);
            4'b10_10: w_coef = CW'(579);
            4'b10_11: w_coef = CW'(-67);
            4'b11_00: w_coef = CW'(-42);
            4'b11_01: w_coef = CW'(281);
            4'b11_10: w_coef = CW'(843);
            4'b11_11: w_coef = CW'(-58);
            default:  w_coef = '0;
        endcase
    end

    // History tap selected by the tap counter
    always_comb begin
        w_xt = r_x0;
        case (r_t)
            2'd0: w_xt = r_x0;
            2'd1: w_xt = r_x1;
            2'd2: w_xt = r_x2;
            2'd3: w_xt = r_x3;
            default: w_xt = r_x0;
        endcase
    end

    // Product formed at accumulator width; low bits are identical to the full product
    assign w_prod  = AW'(w_coef) * AW'(w_xt);
    assign w_sum   = (r_t == 2'd0) ? w_prod : (r_acc + w_prod);
    assign w_y_new = w_sum[SH+DW-1:SH];

    // Sample history shift on each accepted strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x0 <= '0;
            r_x1 <= '0;
            r_x2 <= '0;
            r_x3 <= '0;
        end else if (w_accept) begin
            r_x0 <= r_x1;
            r_x1 <= r_x2;
            r_x2 <= r_x3;
            r_x3 <= $signed(xin);
        end
    end

    // Phase/tap counters and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_p   <= 2'd0;
            r_t   <= 2'd0;
        end else if (r_state == S_OUT0) begin
            r_p <= 2'd1;
            r_t <= 2'd0;
        end else if (r_state == S_MAC) begin
            r_acc <= w_sum;
            if (r_t == 2'd3) begin
                r_t <= 2'd0;
                if (r_p != 2'd3) r_p <= r_p + 2'd1;
            end else begin
                r_t <= r_t + 2'd1;
            end
        end
    end

    // Output register: phase 0 is the plain delayed sample, phases 1..3 the MAC result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_y_phase <= 2'd0;
        end else begin
            r_y_valid <= 1'b0;
            if (r_state == S_OUT0) begin
                r_y       <= r_x1;
                r_y_phase <= 2'd0;
                r_y_valid <= 1'b1;
            end else if (w_last_tap) begin
                r_y       <= w_y_new;
                r_y_phase <= r_p;
                r_y_valid <= 1'b1;
            end
        end
    end

    // Sticky overrun flag; a drop on the same edge as a clear keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (ovr_clr) begin
            r_ovr <= 1'b0;
        end
    end

    assign ready   = w_ready;
    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign y_phase = r_y_phase;
    assign ovr     = r_ovr;

endmodule

// File: tb/tb_interp_phase_scheduler.sv
// tb/tb_interp_phase_scheduler.sv - directed self-checking bench for interp_phase_scheduler
module tb_interp_phase_scheduler;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_valid = 1'b0;
    logic signed [13:0] xin = '0;
    logic              ovr_clr = 1'b0;
    logic              ready;
    logic signed [13:0] y;
    logic              y_valid;
    logic [1:0]        y_phase;
    logic              ovr;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [13:0] got_y  [4];
    logic [1:0]         got_ph [4];
    int                 got_k  [4];
    int                 n_valid;

    interp_phase_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .xin          (xin),
        .ovr_clr      (ovr_clr),
        .ready        (ready),
        .y            (y),
        .y_valid      (y_valid),
        .y_phase      (y_phase),
        .ovr          (ovr)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Strobe x at edge T, optionally inject a strobe/clear at edge T+drop_at,
    // and record every y_valid seen over edges T+1..T+14.
    task automatic burst(input logic signed [13:0] x, input int drop_at,
                         input logic signed [13:0] dx, input logic dclr);
        @(negedge clk);
        sample_valid = 1'b1;
        xin = x;
        n_valid = 0;
        for (int i = 0; i < 4; i++) begin
            got_y[i] = '0; got_ph[i] = '0; got_k[i] = -1;
        end
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k > 1) begin
                if (y_valid) begin
                    if (n_valid < 4) begin
                        got_y[n_valid] = y; got_ph[n_valid] = y_phase; got_k[n_valid] = k - 1;
                    end
                    n_valid++;
                end
            end
            sample_valid = (k == drop_at);
            xin          = (k == drop_at) ? dx : 14'sd0;
            ovr_clr      = dclr && (k == drop_at);
        end
        @(negedge clk);
        if (y_valid) n_valid++;
        sample_valid = 1'b0;
        ovr_clr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (y !== 14'sd0)   begin n_fail++; $display("FAIL reset_y: got %0d expected 0", y); end
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
        n_checks++; if (y_phase !== 2'd0) begin n_fail++; $display("FAIL reset_y_phase: got %0d expected 0", y_phase); end
        n_checks++; if (ovr !== 1'b0)   begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    endtask

    task automatic test_dc();
        do_reset();
        for (int s = 0; s < 4; s++) burst(14'sd1000, 0, 14'sd0, 1'b0);
        n_checks++; if (n_valid !== 4) begin n_fail++; $display("FAIL dc_count: got %0d expected 4", n_valid); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_y[i] !== 14'sd1000) begin n_fail++; $display("FAIL dc_y[%0d]: got %0d expected 1000", i, got_y[i]); end
            n_checks++; if (got_ph[i] !== 2'(i)) begin n_fail++; $display("FAIL dc_phase[%0d]: got %0d expected %0d", i, got_ph[i], i); end
            n_checks++; if (got_k[i] !== 1 + 4 * i) begin n_fail++; $display("FAIL dc_time[%0d]: got T+%0d expected T+%0d", i, got_k[i], 1 + 4 * i); end
        end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL dc_ready: got %b expected 1", ready); end
    endtask

    task automatic test_impulse();
        logic signed [13:0] e1 [4] = '{14'sd0, -14'sd21, -14'sd34, -14'sd29};
        logic signed [13:0] e2 [4] = '{14'sd0, 14'sd140, 14'sd289, 14'sd421};
        do_reset();
        burst(14'sd512, 0, 14'sd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_y[i] !== e1[i]) begin n_fail++; $display("FAIL imp1_y[%0d]: got %0d expected %0d", i, got_y[i], e1[i]); end
        end
        burst(14'sd0, 0, 14'sd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_y[i] !== e2[i]) begin n_fail++; $display("FAIL imp2_y[%0d]: got %0d expected %0d", i, got_y[i], e2[i]); end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        burst(14'sd100, 0, 14'sd0, 1'b0);
        burst(14'sd200, 0, 14'sd0, 1'b0);
        // strobe 300 at T, strobe 400 at T+6 must be dropped
        burst(14'sd300, 6, 14'sd400, 1'b0);
        n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", ovr); end
        n_checks++; if (n_valid !== 4) begin n_fail++; $display("FAIL ovr_count: got %0d expected 4", n_valid); end
        burst(14'sd500, 0, 14'sd0, 1'b0);
        n_checks++; if (got_y[0] !== 14'sd200) begin n_fail++; $display("FAIL ovr_history: got %0d expected 200", got_y[0]); end
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b expected 0", ovr); end
        // drop and clear on the same edge: set wins
        burst(14'sd10, 3, 14'sd20, 1'b1);
        n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b expected 1", ovr); end
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        // strobe at T+13 is still dropped
        burst(14'sd30, 13, 14'sd40, 1'b0);
        n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_t13: got %b expected 1", ovr); end
        n_checks++; if (n_valid !== 4) begin n_fail++; $display("FAIL ovr_t13_count: got %0d expected 4", n_valid); end
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        // strobe held for two cycles in IDLE: accepted once, second cycle dropped
        sample_valid = 1'b1; xin = 14'sd50;
        @(negedge clk); xin = 14'sd60;
        @(negedge clk); sample_valid = 1'b0;
        repeat (14) @(negedge clk);
        n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_held: got %b expected 1", ovr); end
        burst(14'sd70, 0, 14'sd0, 1'b0);
        n_checks++; if (got_y[0] !== 14'sd30) begin n_fail++; $display("FAIL ovr_held_history: got %0d expected 30", got_y[0]); end
    endtask

    task automatic test_wrap();
        do_reset();
        burst(-14'sd8192, 0, 14'sd0, 1'b0);
        burst(14'sd8191, 0, 14'sd0, 1'b0);
        burst(14'sd8191, 0, 14'sd0, 1'b0);
        burst(-14'sd8192, 0, 14'sd0, 1'b0);
        n_checks++; if (got_y[0] !== 14'sd8191) begin n_fail++; $display("FAIL wrap_p0: got %0d expected 8191", got_y[0]); end
        n_checks++; if (got_y[1] !== -14'sd6594) begin n_fail++; $display("FAIL wrap_p1: got %0d expected -6594", got_y[1]); end
        n_checks++; if (got_y[2] !== -14'sd6050) begin n_fail++; $display("FAIL wrap_p2: got %0d expected -6050", got_y[2]); end
        n_checks++; if (got_ph[2] !== 2'd2) begin n_fail++; $display("FAIL wrap_p2_phase: got %0d expected 2", got_ph[2]); end
        n_checks++; if (got_y[3] !== -14'sd6594) begin n_fail++; $display("FAIL wrap_p3: got %0d expected -6594", got_y[3]); end
    endtask

    task automatic test_reset_mid_mac();
        int late_valid;
        do_reset();
        burst(14'sd1000, 0, 14'sd0, 1'b0);
        @(negedge clk); sample_valid = 1'b1; xin = 14'sd1000;
        @(negedge clk); sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        sample_valid = 1'b1; xin = 14'sd7;
        @(negedge clk); sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (y !== 14'sd233) begin n_fail++; $display("FAIL pre_reset_y: got %0d expected 233", y); end
        n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ovr: got %b expected 1", ovr); end
        rst = 1'b1;
        #1;
        n_checks++; if (y !== 14'sd0) begin n_fail++; $display("FAIL midrst_y: got %0d expected 0", y); end
        n_checks++; if (y_phase !== 2'd0) begin n_fail++; $display("FAIL midrst_phase: got %0d expected 0", y_phase); end
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL midrst_ovr: got %b expected 0", ovr); end
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", y_valid); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", ready); end
        late_valid = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (y_valid) late_valid++;
        end
        n_checks++; if (late_valid !== 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d strobes expected 0", late_valid); end
    endtask

    initial begin
        test_reset();
        test_dc();
        test_impulse();
        test_overrun();
        test_wrap();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
